// File: rtl/redmule_tiler_seq.sv
// Sequential tiler: turns M/N/K job sizes into iteration counts, leftovers and
// store totals with a single shared restoring divider, then hands them over via
// a valid/ready handshake.
module redmule_tiler_seq #(
    parameter int unsigned ARRAY_HEIGHT = 8,
    parameter int unsigned PIPE_REGS    = 3,
    parameter int unsigned ARRAY_WIDTH  = ARRAY_HEIGHT * PIPE_REGS,
    parameter int unsigned TILE         = (PIPE_REGS + 1) * ARRAY_HEIGHT,
    parameter int unsigned SIZE_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              start_i,
    input  logic [SIZE_W-1:0] m_size_i,
    input  logic [SIZE_W-1:0] n_size_i,
    input  logic [SIZE_W-1:0] k_size_i,
    output logic              busy_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [SIZE_W-1:0] x_rows_iter_o,
    output logic [7:0]        x_rows_lftovr_o,
    output logic [SIZE_W-1:0] x_cols_iter_o,
    output logic [7:0]        x_cols_lftovr_o,
    output logic [SIZE_W-1:0] w_rows_iter_o,
    output logic [7:0]        w_rows_lftovr_o,
    output logic [SIZE_W-1:0] w_cols_iter_o,
    output logic [7:0]        w_cols_lftovr_o,
    output logic [15:0]       tot_stores_o,
    output logic              n_lt_height_o,
    output logic              k_lt_tile_o,
    output logic              ovf_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(SIZE_W);
    localparam int unsigned REM_W = 9;
    localparam int unsigned LFT_W = 8;

    // Every divisor must fit the 9-bit partial remainder and be non-zero.
    if (ARRAY_HEIGHT == 0 || ARRAY_HEIGHT > 256 || ARRAY_WIDTH == 0 || ARRAY_WIDTH > 256 ||
        TILE == 0 || TILE > 256) begin : g_param_check
        $error("redmule_tiler_seq: every divisor must be in 1..256");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_DIV0, S_DIV1, S_DIV2, S_DIV3, S_MUL, S_DONE
    } state_e;

    state_e state_q, state_d;
    logic   busy_q, valid_q;

    logic [CNT_W-1:0]  cnt_q;
    logic [LFT_W-1:0]  rem_q;
    logic [SIZE_W-1:0] quo_q;
    logic [SIZE_W-1:0] n_q, k_q;

    logic [SIZE_W-1:0] x_rows_iter_q, x_cols_iter_q, w_rows_iter_q, w_cols_iter_q;
    logic [LFT_W-1:0]  x_rows_lft_q, x_cols_lft_q, w_rows_lft_q, w_cols_lft_q;
    logic [15:0]       tot_q;
    logic              n_lt_q, k_lt_q, ovf_q, err_q;

    // Control and datapath signals from the output process
    logic              accept_c, zero_c, div_c, last_c, mul_c;
    logic [REM_W-1:0]  divisor_c, trial_c, rem_nxt_c;
    logic              ge_c;
    logic [SIZE_W-1:0] quo_nxt_c, iter_c, next_dvd_c;
    logic [31:0]       prod_c;

    // State register; busy/valid are registered from the next state
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != S_IDLE);
            valid_q <= (state_d == S_DONE);
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = zero_c ? S_DONE : S_DIV0;
            S_DIV0: if (last_c) state_d = S_DIV1;
            S_DIV1: if (last_c) state_d = S_DIV2;
            S_DIV2: if (last_c) state_d = S_DIV3;
            S_DIV3: if (last_c) state_d = S_MUL;
            S_MUL:  state_d = S_DONE;
            S_DONE: if (ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/control logic: divisor selection, one divider step, product
    always_comb begin
        zero_c     = (m_size_i == '0) || (n_size_i == '0) || (k_size_i == '0);
        accept_c   = (state_q == S_IDLE) && start_i;
        div_c      = 1'b0;
        mul_c      = (state_q == S_MUL);
        last_c     = (cnt_q == CNT_W'(SIZE_W - 1));
        divisor_c  = REM_W'(1);
        next_dvd_c = '0;
        case (state_q)
            S_DIV0: begin div_c = 1'b1; divisor_c = REM_W'(ARRAY_WIDTH);  next_dvd_c = n_q; end
            S_DIV1: begin div_c = 1'b1; divisor_c = REM_W'(TILE);         next_dvd_c = n_q; end
            S_DIV2: begin div_c = 1'b1; divisor_c = REM_W'(ARRAY_HEIGHT); next_dvd_c = k_q; end
            S_DIV3: begin div_c = 1'b1; divisor_c = REM_W'(TILE);         next_dvd_c = '0;  end
            default: ;
        endcase
        trial_c   = {rem_q, quo_q[SIZE_W-1]};
        ge_c      = (trial_c >= divisor_c);
        rem_nxt_c = ge_c ? (trial_c - divisor_c) : trial_c;
        quo_nxt_c = {quo_q[SIZE_W-2:0], ge_c};
        iter_c    = quo_nxt_c + SIZE_W'(rem_nxt_c != '0);
        prod_c    = 32'(x_rows_iter_q) * 32'(w_cols_iter_q);
    end

    // Divider, result and flag registers
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_q <= '0; rem_q <= '0; quo_q <= '0; n_q <= '0; k_q <= '0;
            x_rows_iter_q <= '0; x_cols_iter_q <= '0; w_rows_iter_q <= '0; w_cols_iter_q <= '0;
            x_rows_lft_q  <= '0; x_cols_lft_q  <= '0; w_rows_lft_q  <= '0; w_cols_lft_q  <= '0;
            tot_q <= '0; n_lt_q <= 1'b0; k_lt_q <= 1'b0; ovf_q <= 1'b0; err_q <= 1'b0;
        end else if (accept_c) begin
            cnt_q <= '0; rem_q <= '0; quo_q <= m_size_i; n_q <= n_size_i; k_q <= k_size_i;
            x_rows_iter_q <= '0; x_cols_iter_q <= '0; w_rows_iter_q <= '0; w_cols_iter_q <= '0;
            x_rows_lft_q  <= '0; x_cols_lft_q  <= '0; w_rows_lft_q  <= '0; w_cols_lft_q  <= '0;
            tot_q <= '0; n_lt_q <= 1'b0; k_lt_q <= 1'b0; ovf_q <= 1'b0; err_q <= zero_c;
        end else if (div_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_c) begin
                rem_q <= '0;
                quo_q <= next_dvd_c;
                case (state_q)
                    S_DIV0: begin x_rows_iter_q <= iter_c; x_rows_lft_q <= rem_nxt_c[LFT_W-1:0]; end
                    S_DIV1: begin x_cols_iter_q <= iter_c; x_cols_lft_q <= rem_nxt_c[LFT_W-1:0]; end
                    S_DIV2: begin w_rows_iter_q <= iter_c; w_rows_lft_q <= rem_nxt_c[LFT_W-1:0]; end
                    S_DIV3: begin w_cols_iter_q <= iter_c; w_cols_lft_q <= rem_nxt_c[LFT_W-1:0]; end
                    default: ;
                endcase
            end else begin
                rem_q <= rem_nxt_c[LFT_W-1:0];
                quo_q <= quo_nxt_c;
            end
        end else if (mul_c) begin
            ovf_q  <= (prod_c[31:16] != '0);
            tot_q  <= (prod_c[31:16] != '0) ? 16'hFFFF : prod_c[15:0];
            n_lt_q <= (n_q < SIZE_W'(ARRAY_HEIGHT));
            k_lt_q <= (k_q < SIZE_W'(TILE));
        end
    end

    assign busy_o          = busy_q;
    assign valid_o         = valid_q;
    assign x_rows_iter_o   = x_rows_iter_q;
    assign x_rows_lftovr_o = x_rows_lft_q;
    assign x_cols_iter_o   = x_cols_iter_q;
    assign x_cols_lftovr_o = x_cols_lft_q;
    assign w_rows_iter_o   = w_rows_iter_q;
    assign w_rows_lftovr_o = w_rows_lft_q;
    assign w_cols_iter_o   = w_cols_iter_q;
    assign w_cols_lftovr_o = w_cols_lft_q;
    assign tot_stores_o    = tot_q;
    assign n_lt_height_o   = n_lt_q;
    assign k_lt_tile_o     = k_lt_q;
    assign ovf_o           = ovf_q;
    assign err_o           = err_q;

endmodule

// File: tb/tb_redmule_tiler_seq.sv
// Directed self-checking bench for redmule_tiler_seq. Inputs change and outputs
// are sampled on the falling clock edge.
module tb_redmule_tiler_seq;

    logic        clk_i = 1'b0;
    logic        rst_i, clear_i, start_i, ready_i;
    logic [15:0] m_size_i, n_size_i, k_size_i;
    logic        busy_o, valid_o;
    logic [15:0] x_rows_iter_o, x_cols_iter_o, w_rows_iter_o, w_cols_iter_o, tot_stores_o;
    logic [7:0]  x_rows_lftovr_o, x_cols_lftovr_o, w_rows_lftovr_o, w_cols_lftovr_o;
    logic        n_lt_height_o, k_lt_tile_o, ovf_o, err_o;

    int checks = 0;
    int errors = 0;

    redmule_tiler_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .m_size_i(m_size_i), .n_size_i(n_size_i), .k_size_i(k_size_i),
        .busy_o(busy_o), .valid_o(valid_o), .ready_i(ready_i),
        .x_rows_iter_o(x_rows_iter_o), .x_rows_lftovr_o(x_rows_lftovr_o),
        .x_cols_iter_o(x_cols_iter_o), .x_cols_lftovr_o(x_cols_lftovr_o),
        .w_rows_iter_o(w_rows_iter_o), .w_rows_lftovr_o(w_rows_lftovr_o),
        .w_cols_iter_o(w_cols_iter_o), .w_cols_lftovr_o(w_cols_lftovr_o),
        .tot_stores_o(tot_stores_o), .n_lt_height_o(n_lt_height_o),
        .k_lt_tile_o(k_lt_tile_o), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // Packed view of all numeric results: {x_rows it/lft, x_cols, w_rows, w_cols, tot}
    function automatic logic [111:0] res();
        return {x_rows_iter_o, x_rows_lftovr_o, x_cols_iter_o, x_cols_lftovr_o,
                w_rows_iter_o, w_rows_lftovr_o, w_cols_iter_o, w_cols_lftovr_o, tot_stores_o};
    endfunction

    // {n_lt_height, k_lt_tile, ovf, err}
    function automatic logic [3:0] flags();
        return {n_lt_height_o, k_lt_tile_o, ovf_o, err_o};
    endfunction

    // Launch a job from IDLE and return the cycle valid_o appeared (200 = timeout).
    // With disturb set, a start with other sizes is pulsed at cycle 10 and the
    // size inputs are left changed.
    task automatic start_job(input logic [15:0] m, input logic [15:0] n, input logic [15:0] k,
                             input bit disturb, output int lat);
        m_size_i = m; n_size_i = n; k_size_i = k; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0; lat = 1;
        while (valid_o !== 1'b1 && lat < 200) begin
            if (disturb && lat == 10) begin
                start_i = 1'b1; m_size_i = 16'd1; n_size_i = 16'd1; k_size_i = 16'd1;
            end
            @(negedge clk_i); start_i = 1'b0; lat++;
        end
    endtask

    task automatic handshake();
        ready_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
        m_size_i = 16'd10; n_size_i = 16'd10; k_size_i = 16'd10;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, valid_o} !== 2'b00) begin
            errors++; $display("FAIL reset_ctrl got %b want 00", {busy_o, valid_o});
        end
        checks++;
        if (res() !== '0 || flags() !== 4'b0) begin
            errors++; $display("FAIL reset_outputs got %h/%b want 0/0", res(), flags());
        end
        start_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, valid_o} !== 2'b00) begin
            errors++; $display("FAIL reset_start_blocked got %b want 00", {busy_o, valid_o});
        end
    endtask

    task automatic test_nominal();
        int lat;
        start_job(16'd100, 16'd70, 16'd50, 1'b1, lat);
        checks++;
        if (lat != 66) begin errors++; $display("FAIL nominal_latency got %0d want 66", lat); end
        checks++;
        if (res() !== {16'd5, 8'd4, 16'd3, 8'd6, 16'd9, 8'd6, 16'd2, 8'd18, 16'd10}) begin
            errors++; $display("FAIL nominal_results got %h", res());
        end
        checks++;
        if (flags() !== 4'b0000) begin errors++; $display("FAIL nominal_flags got %b want 0000", flags()); end
        handshake();
        checks++;
        if ({busy_o, valid_o} !== 2'b00 || tot_stores_o !== 16'd10) begin
            errors++; $display("FAIL nominal_release got %b tot %0d want 00 tot 10", {busy_o, valid_o}, tot_stores_o);
        end
    endtask

    task automatic test_small();
        int lat;
        start_job(16'd5, 16'd3, 16'd7, 1'b0, lat);
        checks++;
        if (lat != 66) begin errors++; $display("FAIL small_latency got %0d want 66", lat); end
        checks++;
        if (res() !== {16'd1, 8'd5, 16'd1, 8'd3, 16'd1, 8'd3, 16'd1, 8'd7, 16'd1}) begin
            errors++; $display("FAIL small_results got %h", res());
        end
        checks++;
        if (flags() !== 4'b1100) begin errors++; $display("FAIL small_flags got %b want 1100", flags()); end
        handshake();
    endtask

    task automatic test_exact();
        int lat;
        start_job(16'd24, 16'd8, 16'd32, 1'b0, lat);
        checks++;
        if (res() !== {16'd1, 8'd0, 16'd1, 8'd8, 16'd1, 8'd0, 16'd1, 8'd0, 16'd1} || lat != 66) begin
            errors++; $display("FAIL exact_results got %h lat %0d", res(), lat);
        end
        checks++;
        if (flags() !== 4'b0000) begin errors++; $display("FAIL exact_flags got %b want 0000", flags()); end
        handshake();
    endtask

    task automatic test_max();
        int lat;
        start_job(16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0, lat);
        checks++;
        if (res() !== {16'd2731, 8'd15, 16'd2048, 8'd31, 16'd8192, 8'd7, 16'd2048, 8'd31, 16'hFFFF}) begin
            errors++; $display("FAIL max_results got %h", res());
        end
        checks++;
        if (flags() !== 4'b0010) begin errors++; $display("FAIL max_flags got %b want 0010", flags()); end
        handshake();
    endtask

    task automatic test_error();
        int lat;
        int bad;
        start_job(16'd100, 16'd70, 16'd0, 1'b0, lat);
        checks++;
        if (lat != 1) begin errors++; $display("FAIL err_latency got %0d want 1", lat); end
        checks++;
        if (res() !== '0 || flags() !== 4'b0001) begin
            errors++; $display("FAIL err_outputs got %h/%b want 0/0001", res(), flags());
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start_i = (i == 4);
            m_size_i = 16'd5; n_size_i = 16'd3; k_size_i = 16'd7;
            @(negedge clk_i);
            if (valid_o !== 1'b1 || busy_o !== 1'b1 || res() !== '0 || flags() !== 4'b0001) bad++;
        end
        start_i = 1'b0;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL err_hold got %0d unstable cycles want 0", bad); end
        // Handshake with a simultaneous start: the start must be dropped
        ready_i = 1'b1; start_i = 1'b1;
        @(negedge clk_i);
        ready_i = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if ({busy_o, valid_o} !== 2'b00 || err_o !== 1'b1) begin
            errors++; $display("FAIL err_handshake_start got %b err %b want 00 err 1", {busy_o, valid_o}, err_o);
        end
    endtask

    task automatic test_abort();
        int lat;
        m_size_i = 16'd100; n_size_i = 16'd70; k_size_i = 16'd50; start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (29) @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b1 || x_rows_iter_o !== 16'd5) begin
            errors++; $display("FAIL abort_midjob got busy %b xr %0d want 1 5", busy_o, x_rows_iter_o);
        end
        clear_i = 1'b1;
        @(negedge clk_i); clear_i = 1'b0;
        checks++;
        if ({busy_o, valid_o} !== 2'b00 || res() !== '0 || flags() !== 4'b0) begin
            errors++; $display("FAIL abort_clear got %b %h %b want 00 0 0", {busy_o, valid_o}, res(), flags());
        end
        start_job(16'd5, 16'd3, 16'd7, 1'b0, lat);
        checks++;
        if (lat != 66 || res() !== {16'd1, 8'd5, 16'd1, 8'd3, 16'd1, 8'd3, 16'd1, 8'd7, 16'd1}
            || flags() !== 4'b1100) begin
            errors++; $display("FAIL abort_restart got lat %0d %h %b", lat, res(), flags());
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        int lat;
        start_job(16'd48, 16'd64, 16'd33, 1'b0, lat);
        handshake();
        start_job(16'd49, 16'd9, 16'd96, 1'b0, lat);
        checks++;
        if (lat != 66 || res() !== {16'd3, 8'd1, 16'd1, 8'd9, 16'd2, 8'd1, 16'd3, 8'd0, 16'd9}) begin
            errors++; $display("FAIL b2b_results got lat %0d %h", lat, res());
        end
        checks++;
        if (flags() !== 4'b0000) begin errors++; $display("FAIL b2b_flags got %b want 0000", flags()); end
        handshake();
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_nominal();
        test_small();
        test_exact();
        test_max();
        test_error();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/redmule_tiler_seq.md
Name: redmule_tiler_seq

Overview:
Sequential tiler between the slave register file (M/N/K sizes) and the final register file consumed by the scheduler and streamer controllers. It computes iteration counts, leftovers, total store count and the small-size flags with one shared 16-step restoring divider, which keeps area low. It runs once per job offload and hands the result over with a valid/ready handshake.

Parameters:
ARRAY_HEIGHT, 8, engine rows; divisor for W rows.
PIPE_REGS, 3, CE pipeline depth.
ARRAY_WIDTH, ARRAY_HEIGHT*PIPE_REGS (24), divisor for X/Z rows.
TILE, (PIPE_REGS+1)*ARRAY_HEIGHT (32), divisor for X cols and W cols.
SIZE_W, 16, width of the size inputs and iteration outputs.
- Elaboration-time assertion: every divisor is in 1..256.

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous reset, active-high.
clear_i  in  1  synchronous soft clear; same effect as rst_i.
start_i  in  1  start request; accepted only in IDLE.
m_size_i  in  SIZE_W  M (X/Z rows).
n_size_i  in  SIZE_W  N (X cols = W rows).
k_size_i  in  SIZE_W  K (W/Z cols).
busy_o  out  1  high in every state except IDLE.
valid_o  out  1  results valid (DONE state).
ready_i  in  1  consumer accepts the results.
x_rows_iter_o  out  SIZE_W  ceil(M/ARRAY_WIDTH).
x_rows_lftovr_o  out  8  M mod ARRAY_WIDTH.
x_cols_iter_o  out  SIZE_W  ceil(N/TILE).
x_cols_lftovr_o  out  8  N mod TILE.
w_rows_iter_o  out  SIZE_W  ceil(N/ARRAY_HEIGHT).
w_rows_lftovr_o  out  8  N mod ARRAY_HEIGHT.
w_cols_iter_o  out  SIZE_W  ceil(K/TILE).
w_cols_lftovr_o  out  8  K mod TILE.
tot_stores_o  out  16  x_rows_iter*w_cols_iter, saturated.
n_lt_height_o  out  1  N < ARRAY_HEIGHT.
k_lt_tile_o  out  1  K < TILE.
ovf_o  out  1  tot_stores saturated.
err_o  out  1  a size input was zero.

Behaviour:
- Reset/clear: state IDLE; all outputs and internal registers 0; takes effect the next edge from any state and aborts an ongoing job.
- FSM: IDLE -> DIV0 -> DIV1 -> DIV2 -> DIV3 -> MUL -> DONE -> IDLE.
- IDLE: on start_i, latch m/n/k, then go to DIV0. Exception: if any size is 0, go straight to DONE with err_o=1 and all result outputs 0.
- DIVx: restoring shift-subtract divider, exactly SIZE_W cycles per phase, MSB first, 9-bit partial remainder.
  - DIV0 = M/ARRAY_WIDTH; DIV1 = N/TILE; DIV2 = N/ARRAY_HEIGHT; DIV3 = K/TILE.
  - At the end of each phase: iter = q + (r != 0); lftovr = r zero-extended to 8 bits.
  - iter cannot exceed 2^SIZE_W-1 because the divisor is >= 1 and the ceil adds 1 only when r != 0 (so q < max).
- MUL: 1 cycle. 32-bit product; if it exceeds 0xFFFF then tot_stores=0xFFFF and ovf_o=1. n_lt_height_o and k_lt_tile_o are registered here.
- Latency: start accepted at cycle 0; DIV0 in cycles 1..16, DIV1 17..32, DIV2 33..48, DIV3 49..64, MUL 65; valid_o=1 from cycle 66. Zero-size error path: valid_o=1 at cycle 1.
- DONE: valid_o=1 and outputs stable until valid_o && ready_i; the same edge returns to IDLE. Outputs keep their values in IDLE until the next start is accepted; valid_o drops.
- start_i while busy_o: ignored, not queued. start_i in the same cycle as the DONE handshake: ignored (FSM is not in IDLE).
- Input sizes are sampled only at acceptance; later changes have no effect on the job.
- err_o and ovf_o clear when the next start is accepted.

Test Plan:
- Reset: rst_i high 2 cycles -> busy_o=0, valid_o=0, all outputs 0; 3 cycles with rst_i high and start_i high -> no job starts.
- Nominal: M=100, N=70, K=50 -> valid_o at cycle 66; x_rows 5/4, x_cols 3/6, w_rows 9/6, w_cols 2/18, tot_stores=10, both flags 0, ovf_o=0, err_o=0.
- Small: M=5, N=3, K=7 -> iters 1,1,1,1; lftovrs 5,3,3,7; tot_stores=1; n_lt_height_o=1, k_lt_tile_o=1.
- Exact multiples/max: M=24, N=8, K=32 -> all iters 1, all lftovrs 0 except x_cols_lftovr=8, flags 0. M=N=K=65535 -> x_rows_iter=2731, w_cols_iter=2048, tot_stores=0xFFFF, ovf_o=1.
- Error/handshake: K=0 -> valid_o at cycle 1, err_o=1, all results 0. ready_i held low 10 cycles -> outputs stable; start_i pulsed while busy -> ignored.
- Abort: clear_i at cycle 30 of a job -> IDLE and outputs 0 the next cycle; a new start then completes correctly.
